// File: rtl/vector_instr_queue.sv
// In-order instruction queue feeding vector_top: 1-cycle push-to-head latency, drops FXP_FU encodings.
// Backpressure: push_ready low when full (no same-cycle bypass); head held while a reconfigure waits for vec_idle.
package vector_pkg;
    localparam logic [1:0] INT_FU = 2'd0;
    localparam logic [1:0] FP_FU  = 2'd1;
    localparam logic [1:0] MEM_FU = 2'd2;
    localparam logic [1:0] FXP_FU = 2'd3;

    typedef struct packed {
        logic [1:0]  fu;
        logic [6:0]  microop;
        logic        reconfigure;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [31:0] scalar;
    } to_vector;
endpackage

module vector_instr_queue
    import vector_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  to_vector         push_instr,
    output logic             push_ready,
    output logic             valid_out,
    output to_vector         instr_out,
    input  logic             pop,
    input  logic             vec_idle,
    output logic             illegal_drop,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    to_vector         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             accept;
    logic             wr_en;
    logic             pop_eff;
    to_vector         head;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full && !rst;
    assign accept     = push_valid && push_ready;
    // FXP_FU covers both unsupported fixed-point ops and the bubble encoding.
    assign wr_en      = accept && (push_instr.fu != FXP_FU);

    assign head       = mem[rd_ptr];
    assign valid_out  = !empty && (!head.reconfigure || vec_idle);
    assign instr_out  = empty ? '0 : head;
    assign pop_eff    = pop && valid_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            illegal_drop <= 1'b0;
        end else begin
            illegal_drop <= accept && (push_instr.fu == FXP_FU);
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: instr_out is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= push_instr;
        end
    end
endmodule

// File: tb/tb_vector_instr_queue.sv
// Randomized + directed bench for vector_instr_queue with a queue-based reference model and scoreboard.
module tb_vector_instr_queue;
    import vector_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    to_vector         push_instr;
    logic             push_ready;
    logic             valid_out;
    to_vector         instr_out;
    logic             pop;
    logic             vec_idle;
    logic             illegal_drop;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    to_vector exp_q[$];
    bit       exp_drop = 1'b0;

    vector_instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_instr(push_instr),
        .push_ready(push_ready), .valid_out(valid_out), .instr_out(instr_out),
        .pop(pop), .vec_idle(vec_idle), .illegal_drop(illegal_drop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor + reference model: runs 1 time unit before each rising edge, when inputs are stable.
    always @(negedge clk) begin
        bit exp_valid;
        bit acc;
        #4;
        exp_valid = (exp_q.size() > 0) && (!exp_q[0].reconfigure || vec_idle);
        if (mon_en) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("valid_out", 64'(valid_out), 64'(exp_valid));
            chk("instr_out", 64'(instr_out), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
            chk("illegal_drop", 64'(illegal_drop), 64'(exp_drop));
            chk("push_ready", 64'(push_ready), 64'(!rst && exp_q.size() < DEPTH));
        end
        if (rst) begin
            exp_q.delete();
            exp_drop = 1'b0;
        end else begin
            acc = push_valid && (exp_q.size() < DEPTH);
            exp_drop = acc && (push_instr.fu == FXP_FU);
            if (pop && exp_valid) void'(exp_q.pop_front());
            if (acc && push_instr.fu != FXP_FU) exp_q.push_back(push_instr);
        end
    end

    function automatic to_vector mk(input logic [1:0] fu, input logic [6:0] uop, input logic rc);
        to_vector t;
        t.fu          = fu;
        t.microop     = uop;
        t.reconfigure = rc;
        t.vd          = 5'($urandom);
        t.vs1         = 5'($urandom);
        t.vs2         = 5'($urandom);
        t.scalar      = $urandom;
        return t;
    endfunction

    task automatic step(input logic pv, input to_vector ins, input logic p,
                        input logic idle, input logic r);
        push_valid = pv;
        push_instr = ins;
        pop        = p;
        vec_idle   = idle;
        rst        = r;
        @(negedge clk);
    endtask

    initial begin
        to_vector z;
        z = '0;
        rst = 1'b1; push_valid = 1'b0; push_instr = '0; pop = 1'b0; vec_idle = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        step(0, z, 0, 1, 1);
        step(0, z, 0, 1, 0);

        // Fill, refused 9th push, push+pop at full, then drain.
        for (int k = 1; k <= 8; k++) step(1, mk(INT_FU, 7'(k), 0), 0, 1, 0);
        step(1, mk(INT_FU, 7'd9, 0), 0, 1, 0);
        step(1, mk(INT_FU, 7'd9, 0), 1, 1, 0);
        step(1, mk(INT_FU, 7'd10, 0), 1, 1, 0);
        for (int k = 0; k < 9; k++) step(0, z, 1, 1, 0);

        // Illegal drops into an empty queue.
        step(1, mk(FXP_FU, 7'h7f, 0), 0, 1, 0);
        step(1, mk(FXP_FU, 7'h01, 0), 0, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);

        // Reconfigure interlock.
        step(1, mk(INT_FU, 7'h11, 1), 0, 0, 0);
        step(1, mk(MEM_FU, 7'h00, 0), 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, z, k[0], 0, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 1, 1, 0);
        step(0, z, 0, 0, 0);
        step(0, z, 1, 0, 0);
        step(0, z, 0, 1, 0);

        // Reset mid-stream with five entries and a pending drop pulse.
        for (int k = 0; k < 5; k++) step(1, mk(FP_FU, 7'(k + 3), 0), 0, 1, 0);
        step(1, mk(FXP_FU, 7'h05, 0), 0, 1, 0);
        step(1, mk(INT_FU, 7'h33, 0), 0, 1, 1);
        step(1, mk(INT_FU, 7'h34, 0), 0, 1, 0);
        step(0, z, 1, 1, 0);
        step(0, z, 0, 1, 0);

        // Push into empty with same-cycle pop.
        step(1, mk(FP_FU, 7'h02, 0), 1, 1, 0);
        step(0, z, 0, 1, 0);
        step(0, z, 1, 1, 0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] fu;
            fu = 2'($urandom);
            step(1'($urandom_range(0, 2) != 0), mk(fu, 7'($urandom), 1'($urandom_range(0, 7) == 0)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 199) == 0));
        end
        step(0, z, 0, 1, 0);
        step(0, z, 0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
